// File: rtl/pc_fetch_unit.sv
// PC stage: holds the fetch address, selects the next PC and tracks
// run/halt/fault state plus a retired-instruction count.
module pc_fetch_unit #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned INSTR_WIDTH   = 32,
  parameter int unsigned MEM_DEPTH     = 100,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_ADDRESS = '0,
  parameter logic [INSTR_WIDTH-1:0]   HALT_WORD     = '1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Stall,
  input  logic                     Branch,
  input  logic                     Zero,
  input  logic [31:0]              SignImm,
  input  logic                     Jump,
  input  logic [25:0]              JumpIndex,
  input  logic                     JumpReg,
  input  logic [ADDRESS_WIDTH-1:0] RegTarget,
  input  logic [INSTR_WIDTH-1:0]   Instr,
  output logic [ADDRESS_WIDTH-1:0] InstrAddress,
  output logic [ADDRESS_WIDTH-1:0] PCPlus4,
  output logic                     Running,
  output logic                     Halted,
  output logic                     Fault,
  output logic [31:0]              RetiredCount
);

  localparam int unsigned AW = ADDRESS_WIDTH;
  localparam logic [AW-1:0] LIMIT = AW'(MEM_DEPTH * 4);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT,
    FAULT
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [AW-1:0] br_tgt, j_tgt, next_pc;
  logic          illegal;

  assign PCPlus4 = pc_q + AW'(4);
  assign br_tgt  = PCPlus4 + AW'($signed({SignImm, 2'b00}));
  assign j_tgt   = {PCPlus4[AW-1:28], JumpIndex, 2'b00};

  always_comb begin
    next_pc = PCPlus4;
    priority case (1'b1)
      JumpReg:         next_pc = RegTarget;
      Jump:            next_pc = j_tgt;
      Branch && Zero:  next_pc = br_tgt;
      default:         next_pc = PCPlus4;
    endcase
  end

  // PC+4 wrapping to zero is covered because the old PC was already legal
  assign illegal = (next_pc[1:0] != 2'b00) || (next_pc >= LIMIT);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (!Stall) begin
          if (Instr == HALT_WORD) begin
            state_d = HALT;
          end else if (illegal) begin
            state_d = FAULT;
          end else begin
            pc_d  = next_pc;
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= BOOT;
      pc_q    <= RESET_ADDRESS;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign InstrAddress = pc_q;
  assign RetiredCount = cnt_q;
  assign Running      = (state_q == RUN);
  assign Halted       = (state_q == HALT);
  assign Fault        = (state_q == FAULT);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed vector table, corner sequences
// and randomized traffic against a behavioural model.
module tb_pc_fetch_unit;

  localparam logic [31:0] HALTW = 32'hFFFF_FFFF;
  localparam longint LIM = 400;

  logic        CLK, RST, Stall, Branch, Zero, Jump, JumpReg;
  logic [31:0] SignImm, RegTarget, Instr;
  logic [25:0] JumpIndex;
  logic [31:0] InstrAddress, PCPlus4, RetiredCount;
  logic        Running, Halted, Fault;

  int nchk = 0;
  int nerr = 0;

  pc_fetch_unit dut (
    .CLK(CLK), .RST(RST), .Stall(Stall), .Branch(Branch),
    .Zero(Zero), .SignImm(SignImm), .Jump(Jump),
    .JumpIndex(JumpIndex), .JumpReg(JumpReg),
    .RegTarget(RegTarget), .Instr(Instr),
    .InstrAddress(InstrAddress), .PCPlus4(PCPlus4),
    .Running(Running), .Halted(Halted), .Fault(Fault),
    .RetiredCount(RetiredCount)
  );

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic        stall, br, zero;
    logic [31:0] imm;
    logic        jmp;
    logic [25:0] idx;
    logic        jr;
    logic [31:0] rt, instr;
    logic [31:0] epc, ecnt;
    logic        erun, ehalt, efault;
  } vec_t;

  vec_t tbl[$];

  // behavioural reference state
  logic [31:0] m_pc, m_cnt;
  logic        m_boot, m_run, m_halt, m_fault;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(logic st, logic b, logic z, logic [31:0] im,
                       logic j, logic [25:0] ix, logic r,
                       logic [31:0] t, logic [31:0] ins);
    Stall = st; Branch = b; Zero = z; SignImm = im;
    Jump = j; JumpIndex = ix; JumpReg = r; RegTarget = t;
    Instr = ins;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // async reset issued 1ns after an edge, released before the next one
  task automatic do_reset();
    idle();
    RST = 0;
    #2;
    chk("rst_pc", InstrAddress, 32'h0);
    chk("rst_p4", PCPlus4, 32'h4);
    chk("rst_cnt", RetiredCount, 32'h0);
    chk("rst_flags", {29'd0, Running, Halted, Fault}, 32'h0);
    RST = 1;
    m_pc = 0; m_cnt = 0; m_boot = 1;
    m_run = 0; m_halt = 0; m_fault = 0;
  endtask

  task automatic expect_state(string nm, logic [31:0] pc,
                              logic [31:0] cnt, logic r,
                              logic h, logic f);
    chk({nm, "_pc"}, InstrAddress, pc);
    chk({nm, "_cnt"}, RetiredCount, cnt);
    chk({nm, "_flags"}, {29'd0, Running, Halted, Fault},
        {29'd0, r, h, f});
  endtask

  task automatic model_step();
    longint p4, t;
    if (m_boot) begin
      m_boot = 0;
      m_run = 1;
    end else if (m_run && !Stall) begin
      p4 = (longint'(m_pc) + 4) % 64'h1_0000_0000;
      if (JumpReg)
        t = longint'(RegTarget);
      else if (Jump)
        t = (p4 / 64'h1000_0000) * 64'h1000_0000
            + longint'(JumpIndex) * 4;
      else if (Branch && Zero)
        t = (p4 + 4 * longint'($signed(SignImm)))
            & 64'hFFFF_FFFF;
      else
        t = p4;
      if (Instr == HALTW) begin
        m_run = 0; m_halt = 1;
      end else if ((t % 4) != 0 || t >= LIM) begin
        m_run = 0; m_fault = 1;
      end else begin
        m_pc = t[31:0];
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  function automatic vec_t mk(logic st, logic b, logic z,
                              logic [31:0] im, logic j,
                              logic [25:0] ix, logic r,
                              logic [31:0] t, logic [31:0] ins,
                              logic [31:0] pc, logic [31:0] c,
                              logic er, logic eh, logic ef);
    vec_t v;
    v.stall = st; v.br = b; v.zero = z; v.imm = im;
    v.jmp = j; v.idx = ix; v.jr = r; v.rt = t; v.instr = ins;
    v.epc = pc; v.ecnt = c;
    v.erun = er; v.ehalt = eh; v.efault = ef;
    return v;
  endfunction

  initial begin
    RST = 0;
    idle();
    #3;
    RST = 1;
    m_pc = 0; m_cnt = 0; m_boot = 1;
    m_run = 0; m_halt = 0; m_fault = 0;
    expect_state("init", 32'h0, 32'h0, 0, 0, 0);

    // one row per clock, starting from reset release
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 32'h00, 0, 1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 32'h04, 1, 1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 32'h08, 2, 1,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,HALTW, 32'h08, 2, 1,0,0));
    tbl.push_back(mk(1,0,0,0,1,3,0,0,0, 32'h08, 2, 1,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,1,32'h42,0, 32'h08, 2, 1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 32'h0C, 3, 1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 32'h10, 4, 1,0,0));
    tbl.push_back(mk(0,1,1,-32'sd2,0,0,0,0,0, 32'h0C, 5, 1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 32'h10, 6, 1,0,0));
    tbl.push_back(mk(0,1,0,-32'sd2,0,0,0,0,0, 32'h14, 7, 1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 32'h18, 8, 1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 32'h1C, 9, 1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 32'h20, 10, 1,0,0));
    tbl.push_back(mk(0,0,0,0,1,5,1,32'h40,0, 32'h40, 11, 1,0,0));
    tbl.push_back(mk(0,0,0,0,1,5,0,0,0, 32'h14, 12, 1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 32'h18, 13, 1,0,0));
    tbl.push_back(mk(0,0,0,0,1,7,0,0,HALTW, 32'h18, 13, 0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 32'h18, 13, 0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,1,32'h0,0, 32'h18, 13, 0,1,0));

    foreach (tbl[i]) begin
      drive(tbl[i].stall, tbl[i].br, tbl[i].zero, tbl[i].imm,
            tbl[i].jmp, tbl[i].idx, tbl[i].jr, tbl[i].rt,
            tbl[i].instr);
      step();
      expect_state($sformatf("vec%0d", i), tbl[i].epc,
                   tbl[i].ecnt, tbl[i].erun, tbl[i].ehalt,
                   tbl[i].efault);
    end
    chk("vec_p4", PCPlus4, 32'h1C);

    // misaligned JR target
    do_reset();
    step();
    drive(0,0,0,0,0,0,1,32'h42,0);
    step();
    expect_state("jr42", 32'h0, 0, 0, 0, 1);
    idle();
    step();
    expect_state("jr42_hold", 32'h0, 0, 0, 0, 1);

    // out-of-range JR target
    do_reset();
    step();
    drive(0,0,0,0,0,0,1,32'h190,0);
    step();
    expect_state("jr190", 32'h0, 0, 0, 0, 1);

    // last legal word, then sequential step past the end
    do_reset();
    step();
    drive(0,0,0,0,0,0,1,32'h18C,0);
    step();
    expect_state("jr18c", 32'h18C, 1, 1, 0, 0);
    chk("p4_18c", PCPlus4, 32'h190);
    idle();
    step();
    expect_state("seq_end", 32'h18C, 1, 0, 0, 1);

    // halt wins over an illegal target in the same cycle
    do_reset();
    step();
    drive(0,0,0,0,0,0,1,32'h43,HALTW);
    step();
    expect_state("halt_vs_fault", 32'h0, 0, 0, 1, 0);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (((m_halt || m_fault) && $urandom_range(0, 3) == 0) ||
          $urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        Stall   = ($urandom_range(0, 5) == 0);
        Branch  = $urandom_range(0, 1);
        Zero    = $urandom_range(0, 1);
        SignImm = 32'($signed($urandom_range(0, 60)) - 30);
        Jump    = ($urandom_range(0, 7) == 0);
        JumpIndex = 26'($urandom_range(0, 110));
        JumpReg = ($urandom_range(0, 9) == 0);
        RegTarget = ($urandom_range(0, 3) == 0) ? $urandom()
                  : 32'($urandom_range(0, 99) * 4);
        Instr = ($urandom_range(0, 60) == 0) ? HALTW : $urandom();
        if (Instr == HALTW && $urandom_range(0, 1) == 0)
          Instr = 32'h0;
        model_step();
        step();
        expect_state("rnd", m_pc, m_cnt, m_run, m_halt, m_fault);
        chk("rnd_p4", PCPlus4, m_pc + 32'd4);
      end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
